// File: rtl/decodificador_dispensador.sv
// Product-side decoder/dispenser: latches a confirmed product code, checks its
// stock, then drives the product motor for a fixed time or flags sold-out.
module decodificador_dispensador #(
  parameter int ESTOQUE_INICIAL = 3,
  parameter int TEMPO_LIBERA    = 8,
  parameter int TEMPO_ERRO      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  codigo,
  input  logic        confirma,
  input  logic        repor,
  output logic        pronto,
  output logic [3:0]  tecla_linha,
  output logic [3:0]  tecla_coluna,
  output logic [15:0] produto,
  output logic        liberado,
  output logic        esgotado,
  output logic [3:0]  estoque_atual
);

  localparam int TEMPO_MAX = (TEMPO_LIBERA > TEMPO_ERRO) ? TEMPO_LIBERA : TEMPO_ERRO;
  localparam int CW        = $clog2(TEMPO_MAX + 1);

  localparam logic [3:0]    ESTOQUE_INI = 4'(ESTOQUE_INICIAL);
  localparam logic [CW-1:0] CNT_LIBERA  = CW'(TEMPO_LIBERA);
  localparam logic [CW-1:0] CNT_ERRO    = CW'(TEMPO_ERRO);
  localparam logic [CW-1:0] CNT_UM      = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VERIFICA = 2'd1,
    LIBERA   = 2'd2,
    ERRO     = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    codigo_q, codigo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    estoque_q [16];
  logic [3:0]    estoque_d [16];

  // Next-state logic: FSM transitions, code latch, timer and stock updates
  always_comb begin
    estado_d  = estado_q;
    codigo_d  = codigo_q;
    cnt_d     = cnt_q;
    estoque_d = estoque_q;
    case (estado_q)
      IDLE: begin
        // restock has priority; a simultaneous confirm is dropped
        if (repor) begin
          for (int i = 0; i < 16; i++) begin
            estoque_d[i] = ESTOQUE_INI;
          end
        end else if (confirma) begin
          codigo_d = codigo;
          estado_d = VERIFICA;
        end else begin
          estado_d = IDLE;
        end
      end
      VERIFICA: begin
        if (estoque_q[codigo_q] == 4'd0) begin
          cnt_d    = CNT_ERRO;
          estado_d = ERRO;
        end else begin
          cnt_d    = CNT_LIBERA;
          estado_d = LIBERA;
        end
      end
      LIBERA: begin
        cnt_d = cnt_q - CNT_UM;
        if (cnt_q == CNT_UM) begin
          estoque_d[codigo_q] = estoque_q[codigo_q] - 4'd1;
          estado_d            = IDLE;
        end else begin
          estado_d = LIBERA;
        end
      end
      ERRO: begin
        cnt_d = cnt_q - CNT_UM;
        if (cnt_q == CNT_UM) begin
          estado_d = IDLE;
        end else begin
          estado_d = ERRO;
        end
      end
      default: begin
        estado_d = IDLE;
        cnt_d    = CNT_ZERO;
      end
    endcase
  end

  // State registers with synchronous reset; reset also reloads every stock count
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= IDLE;
      codigo_q <= 4'd0;
      cnt_q    <= CNT_ZERO;
      for (int i = 0; i < 16; i++) begin
        estoque_q[i] <= ESTOQUE_INI;
      end
    end else begin
      estado_q  <= estado_d;
      codigo_q  <= codigo_d;
      cnt_q     <= cnt_d;
      estoque_q <= estoque_d;
    end
  end

  // Output decode, purely from registered state
  always_comb begin
    pronto        = 1'b0;
    produto       = 16'h0000;
    liberado      = 1'b0;
    esgotado      = 1'b0;
    tecla_linha   = 4'b0001 << codigo_q[3:2];
    tecla_coluna  = 4'b0001 << codigo_q[1:0];
    estoque_atual = estoque_q[codigo_q];
    case (estado_q)
      IDLE: begin
        pronto = 1'b1;
      end
      VERIFICA: begin
        pronto = 1'b0;
      end
      LIBERA: begin
        produto  = 16'h0001 << codigo_q;
        liberado = (cnt_q == CNT_UM);
      end
      ERRO: begin
        esgotado = 1'b1;
      end
      default: begin
        pronto = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_decodificador_dispensador.sv
// Directed self-checking bench for decodificador_dispensador (default parameters).
module tb_decodificador_dispensador;

  localparam int T_LIB = 8;
  localparam int T_ERR = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  codigo;
  logic        confirma;
  logic        repor;
  logic        pronto;
  logic [3:0]  tecla_linha;
  logic [3:0]  tecla_coluna;
  logic [15:0] produto;
  logic        liberado;
  logic        esgotado;
  logic [3:0]  estoque_atual;

  int total = 0;
  int bad   = 0;

  decodificador_dispensador #(
    .ESTOQUE_INICIAL(3),
    .TEMPO_LIBERA(T_LIB),
    .TEMPO_ERRO(T_ERR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .codigo(codigo),
    .confirma(confirma),
    .repor(repor),
    .pronto(pronto),
    .tecla_linha(tecla_linha),
    .tecla_coluna(tecla_coluna),
    .produto(produto),
    .liberado(liberado),
    .esgotado(esgotado),
    .estoque_atual(estoque_atual)
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // confirm a code; returns in cycle 1 (VERIFICA)
  task automatic pulse_confirma(input logic [3:0] c);
    codigo   = c;
    confirma = 1'b1;
    step();
    confirma = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; confirma = 1'b0; repor = 1'b0; codigo = 4'd0;
    step(); step();
    reset = 1'b0;
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL reset_pronto got=%b exp=1", pronto); end
    total++; if (produto !== 16'h0000) begin bad++; $display("FAIL reset_produto got=%h exp=0000", produto); end
    total++; if (liberado !== 1'b0) begin bad++; $display("FAIL reset_liberado got=%b exp=0", liberado); end
    total++; if (esgotado !== 1'b0) begin bad++; $display("FAIL reset_esgotado got=%b exp=0", esgotado); end
    total++; if (tecla_linha !== 4'b0001) begin bad++; $display("FAIL reset_linha got=%b exp=0001", tecla_linha); end
    total++; if (tecla_coluna !== 4'b0001) begin bad++; $display("FAIL reset_coluna got=%b exp=0001", tecla_coluna); end
    total++; if (estoque_atual !== 4'd3) begin bad++; $display("FAIL reset_estoque got=%0d exp=3", estoque_atual); end
  endtask

  task automatic test_dispense();
    pulse_confirma(4'b0110);
    total++; if (pronto !== 1'b0) begin bad++; $display("FAIL disp_c1_pronto got=%b exp=0", pronto); end
    total++; if (tecla_linha !== 4'b0010) begin bad++; $display("FAIL disp_linha got=%b exp=0010", tecla_linha); end
    total++; if (tecla_coluna !== 4'b0100) begin bad++; $display("FAIL disp_coluna got=%b exp=0100", tecla_coluna); end
    total++; if (produto !== 16'h0000) begin bad++; $display("FAIL disp_c1_produto got=%h exp=0000", produto); end
    for (int c = 2; c <= T_LIB + 1; c++) begin
      step();
      total++; if (produto !== 16'h0040) begin bad++; $display("FAIL disp_produto cyc=%0d got=%h exp=0040", c, produto); end
      total++; if (liberado !== (c == T_LIB + 1)) begin bad++; $display("FAIL disp_liberado cyc=%0d got=%b exp=%b", c, liberado, (c == T_LIB + 1)); end
    end
    step();
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL disp_end_pronto got=%b exp=1", pronto); end
    total++; if (produto !== 16'h0000) begin bad++; $display("FAIL disp_end_produto got=%h exp=0000", produto); end
    total++; if (estoque_atual !== 4'd2) begin bad++; $display("FAIL disp_end_estoque got=%0d exp=2", estoque_atual); end
  endtask

  task automatic test_sold_out();
    for (int k = 0; k < 3; k++) begin
      pulse_confirma(4'hF);
      for (int c = 2; c <= T_LIB + 2; c++) step();
      total++; if (estoque_atual !== 4'(2 - k)) begin bad++; $display("FAIL soldout_stock k=%0d got=%0d exp=%0d", k, estoque_atual, 2 - k); end
      total++; if (pronto !== 1'b1) begin bad++; $display("FAIL soldout_pronto k=%0d got=%b exp=1", k, pronto); end
    end
    pulse_confirma(4'hF);
    for (int c = 2; c <= T_ERR + 1; c++) begin
      step();
      total++; if (esgotado !== 1'b1) begin bad++; $display("FAIL soldout_esgotado cyc=%0d got=%b exp=1", c, esgotado); end
      total++; if (produto !== 16'h0000) begin bad++; $display("FAIL soldout_produto cyc=%0d got=%h exp=0000", c, produto); end
      total++; if (liberado !== 1'b0) begin bad++; $display("FAIL soldout_liberado cyc=%0d got=%b exp=0", c, liberado); end
    end
    step();
    total++; if (esgotado !== 1'b0) begin bad++; $display("FAIL soldout_end_esgotado got=%b exp=0", esgotado); end
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL soldout_end_pronto got=%b exp=1", pronto); end
    total++; if (estoque_atual !== 4'd0) begin bad++; $display("FAIL soldout_end_stock got=%0d exp=0", estoque_atual); end
  endtask

  task automatic test_ignored_confirm();
    pulse_confirma(4'h5);
    for (int c = 2; c <= T_LIB + 1; c++) begin
      if (c == 4) begin codigo = 4'h3; confirma = 1'b1; end
      else confirma = 1'b0;
      step();
      total++; if (produto !== 16'h0020) begin bad++; $display("FAIL ign_produto cyc=%0d got=%h exp=0020", c, produto); end
    end
    confirma = 1'b0;
    step();
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL ign_pronto got=%b exp=1", pronto); end
    total++; if (tecla_linha !== 4'b0010 || tecla_coluna !== 4'b0010) begin bad++; $display("FAIL ign_code got=%b/%b exp=0010/0010", tecla_linha, tecla_coluna); end
    total++; if (estoque_atual !== 4'd2) begin bad++; $display("FAIL ign_stock5 got=%0d exp=2", estoque_atual); end
    pulse_confirma(4'h3);
    total++; if (estoque_atual !== 4'd3) begin bad++; $display("FAIL ign_stock3 got=%0d exp=3", estoque_atual); end
    for (int c = 2; c <= T_LIB + 2; c++) step();
    total++; if (estoque_atual !== 4'd2) begin bad++; $display("FAIL ign_stock3_after got=%0d exp=2", estoque_atual); end
  endtask

  task automatic test_restock();
    for (int k = 0; k < 3; k++) begin
      pulse_confirma(4'h0);
      for (int c = 2; c <= T_LIB + 2; c++) step();
    end
    total++; if (estoque_atual !== 4'd0) begin bad++; $display("FAIL rst_exhausted got=%0d exp=0", estoque_atual); end
    codigo = 4'h0; repor = 1'b1; confirma = 1'b1;
    step();
    repor = 1'b0; confirma = 1'b0;
    total++; if (estoque_atual !== 4'd3) begin bad++; $display("FAIL rst_stock got=%0d exp=3", estoque_atual); end
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL rst_pronto got=%b exp=1", pronto); end
    step();
    total++; if (pronto !== 1'b1 || produto !== 16'h0000) begin bad++; $display("FAIL rst_no_disp got=%b/%h exp=1/0000", pronto, produto); end
    pulse_confirma(4'h0);
    step();
    total++; if (produto !== 16'h0001) begin bad++; $display("FAIL rst_disp_produto got=%h exp=0001", produto); end
    for (int c = 3; c <= T_LIB + 2; c++) step();
    total++; if (estoque_atual !== 4'd2) begin bad++; $display("FAIL rst_disp_stock got=%0d exp=2", estoque_atual); end
    pulse_confirma(4'hF);
    total++; if (estoque_atual !== 4'd3) begin bad++; $display("FAIL rst_stockF got=%0d exp=3", estoque_atual); end
    for (int c = 2; c <= T_LIB + 2; c++) step();
  endtask

  task automatic test_reset_mid();
    pulse_confirma(4'h9);
    for (int c = 2; c <= 4; c++) step();
    total++; if (produto !== 16'h0200) begin bad++; $display("FAIL mid_produto got=%h exp=0200", produto); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL mid_pronto got=%b exp=1", pronto); end
    total++; if (produto !== 16'h0000) begin bad++; $display("FAIL mid_produto_after got=%h exp=0000", produto); end
    total++; if (estoque_atual !== 4'd3) begin bad++; $display("FAIL mid_stock0 got=%0d exp=3", estoque_atual); end
    for (int c = 0; c < T_LIB + 2; c++) begin
      step();
      total++; if (liberado !== 1'b0) begin bad++; $display("FAIL mid_liberado cyc=%0d got=%b exp=0", c, liberado); end
    end
    pulse_confirma(4'h9);
    total++; if (estoque_atual !== 4'd3) begin bad++; $display("FAIL mid_stock9 got=%0d exp=3", estoque_atual); end
    for (int c = 2; c <= T_LIB + 2; c++) step();
  endtask

  task automatic test_back_to_back();
    pulse_confirma(4'hA);
    for (int c = 2; c <= T_LIB + 2; c++) step();
    total++; if (pronto !== 1'b1) begin bad++; $display("FAIL b2b_pronto got=%b exp=1", pronto); end
    pulse_confirma(4'hA);
    total++; if (pronto !== 1'b0 || estoque_atual !== 4'd2) begin bad++; $display("FAIL b2b_second got=%b/%0d exp=0/2", pronto, estoque_atual); end
    step();
    total++; if (produto !== 16'h0400) begin bad++; $display("FAIL b2b_produto got=%h exp=0400", produto); end
    for (int c = 3; c <= T_LIB + 2; c++) step();
    total++; if (estoque_atual !== 4'd1) begin bad++; $display("FAIL b2b_stock got=%0d exp=1", estoque_atual); end
  endtask

  initial begin
    test_reset();
    test_dispense();
    test_sold_out();
    test_ignored_confirm();
    test_restock();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decodificador_dispensador.md
# decodificador_dispensador

Product-side counterpart of the keypad code generator in the vending machine. It accepts a confirmed 4-bit product code and decodes it back into the two keypad selections (row and column, one-hot). It checks a per-product stock counter, then either drives the selected product's dispense motor for a fixed time or signals "sold out". It sits between the code generator / main controller and the dispenser motors and the status display.

## Interface
Parameters:
- `ESTOQUE_INICIAL`, default 3: units loaded per product at reset and on restock; legal range 0..15.
- `TEMPO_LIBERA`, default 8: cycles the motor enable is held; must be ≥1.
- `TEMPO_ERRO`, default 8: cycles the sold-out flag is held; must be ≥1.

Ports:
- `clk`, in, 1: single system clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `codigo`, in, 4: product code; `codigo[3:2]` is the first digit, `codigo[1:0]` is the second digit.
- `confirma`, in, 1: one-cycle strobe requesting a dispense of `codigo`.
- `repor`, in, 1: one-cycle strobe that restocks every product to `ESTOQUE_INICIAL`.
- `pronto`, out, 1: high while in IDLE; requests are accepted only then.
- `tecla_linha`, out, 4: one-hot decode of the latched `codigo[3:2]`.
- `tecla_coluna`, out, 4: one-hot decode of the latched `codigo[1:0]`.
- `produto`, out, 16: one-hot motor enable; bit = latched code, asserted only in LIBERA.
- `liberado`, out, 1: one-cycle pulse on the last LIBERA cycle.
- `esgotado`, out, 1: high throughout ERRO.
- `estoque_atual`, out, 4: stock count of the latched code.

## Operation
- State is held in a 16×4-bit stock array, a 4-bit `codigo_reg`, and a down-counter sized for max(`TEMPO_LIBERA`, `TEMPO_ERRO`).
- FSM states are IDLE, VERIFICA, LIBERA and ERRO.
- IDLE:
  - `confirma`=1 and `repor`=0: latch `codigo` into `codigo_reg`, then go to VERIFICA.
  - `repor`=1: set all 16 counters to `ESTOQUE_INICIAL` and stay in IDLE. `repor` wins over a simultaneous `confirma`; that `confirma` is dropped.
- VERIFICA lasts one cycle.
  - If stock[`codigo_reg`]==0, load the counter with `TEMPO_ERRO` and go to ERRO.
  - Otherwise load the counter with `TEMPO_LIBERA` and go to LIBERA.
- LIBERA: `produto[codigo_reg]`=1 and the counter decrements each cycle. On the last cycle:
  - `liberado`=1;
  - stock[`codigo_reg`] decrements by 1;
  - the next state is IDLE.
- ERRO: `esgotado`=1 and the counter decrements; on the last cycle the next state is IDLE. Stock is unchanged.
- `confirma` and `repor` outside IDLE are ignored, with no queuing.
- Stock never underflows, because VERIFICA filters zero counts. Decrement arithmetic is 4-bit unsigned.
- Decode outputs:
  - `tecla_linha` = 1<<`codigo_reg[3:2]`, `tecla_coluna` = 1<<`codigo_reg[1:0]`; both always exactly one-hot.
  - `estoque_atual` = stock[`codigo_reg`], combinational from the registers.
- Reset while `reset`=1 at a rising edge:
  - state IDLE; `codigo_reg`=0; all stock = `ESTOQUE_INICIAL`; counter 0.
  - After that edge: `pronto`=1, `produto`=0, `liberado`=0, `esgotado`=0, `tecla_linha`=4'b0001, `tecla_coluna`=4'b0001, `estoque_atual`=`ESTOQUE_INICIAL`.
- Reset mid-operation aborts LIBERA or ERRO immediately. No decrement is applied for an aborted dispense.

## Timing
- Cycle 0: `confirma` sampled high in IDLE. In cycle 1 the state is VERIFICA, `pronto`=0, and the decode outputs show the new code.
- Dispense path:
  - Cycles 2..`TEMPO_LIBERA`+1: `produto` asserted.
  - Cycle `TEMPO_LIBERA`+1: `liberado`=1.
  - Cycle `TEMPO_LIBERA`+2: IDLE, `pronto`=1, `estoque_atual` shows the decremented value.
- Error path:
  - Cycles 2..`TEMPO_ERRO`+1: `esgotado`=1.
  - Cycle `TEMPO_ERRO`+2: IDLE.
- Restock in IDLE at cycle N: new counts are visible in cycle N+1.
- A new `confirma` is accepted in the first cycle `pronto`=1 is seen. Back-to-back dispenses are therefore `TEMPO_LIBERA`+2 cycles apart.
- All outputs are registered-state functions with no combinational path from inputs. Exception: none; `estoque_atual` derives from registers only.

## Test plan
- Reset with defaults → `pronto`=1, `produto`=0, `liberado`=0, `esgotado`=0, `tecla_linha`=0001, `tecla_coluna`=0001, `estoque_atual`=3.
- `codigo`=4'b0110, `confirma` pulse → `tecla_linha`=0010, `tecla_coluna`=0100, `produto`=16'h0040 for cycles 2..9, `liberado` in cycle 9, `pronto` in cycle 10, `estoque_atual`=2.
- Four dispenses of code 4'hF → first three dispense and stock reaches 0. The fourth gives `esgotado`=1 in cycles 2..9, `produto` stays 0, stock stays 0.
- `confirma` with code 4'h3 during LIBERA of code 4'h5 → ignored; only bit 5 is pulsed, stock[3] is unchanged.
- Exhaust code 4'h0, then `repor` and `confirma` in the same IDLE cycle → no dispense, stock[0]=3 next cycle. A following `confirma` dispenses normally.
- `reset` in cycle 4 of a LIBERA → next cycle IDLE, `produto`=0, `liberado` never pulses, stock = `ESTOQUE_INICIAL`.
